// File: rtl/wb_slave_mux.sv
// rtl/wb_slave_mux.sv - single-master Wishbone decoder to four slaves with ack watchdog
module wb_slave_mux #(
    parameter int         DATA_WIDTH = 16,
    parameter int         ADDR_WIDTH = 8,
    parameter logic [3:0] SLAVE_MASK = 4'b1111,
    parameter int         TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wbCycI,
    input  logic                    wbStbI,
    input  logic                    wbWeI,
    input  logic [ADDR_WIDTH-1:0]   wbAdrI,
    input  logic [DATA_WIDTH-1:0]   wbDatI,
    output logic [DATA_WIDTH-1:0]   wbDatO,
    output logic                    wbAckO,
    output logic                    wbErrO,
    output logic                    sCycO,
    output logic [3:0]              sStbO,
    output logic                    sWeO,
    output logic [ADDR_WIDTH-3:0]   sAdrO,
    output logic [DATA_WIDTH-1:0]   sDatO,
    input  logic [4*DATA_WIDTH-1:0] sDatI,
    input  logic [3:0]              sAckI
);

    // The watchdog counter is 8 bits wide and must never need to wrap.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_slave_mux: TIMEOUT must be in 1..255");
    end
    if (ADDR_WIDTH < 3) begin : g_bad_addr
        $error("wb_slave_mux: ADDR_WIDTH must be at least 3");
    end

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t     state_q;
    logic [1:0] sel_q;
    logic [7:0] cnt_q;
    logic       err_q;
    logic       busy;
    logic [1:0] adr_sel;

    assign adr_sel = wbAdrI[ADDR_WIDTH-1:ADDR_WIDTH-2];
    assign busy    = (state_q == ST_BUSY);

    // Access sequencer: decode in IDLE, wait for ack or watchdog in BUSY, one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wbCycI && wbStbI) begin
                        sel_q <= adr_sel;
                        cnt_q <= 8'd0;
                        if (SLAVE_MASK[adr_sel]) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (sAckI[sel_q]) begin
                        state_q <= ST_IDLE;
                    end else if (!wbCycI) begin
                        // Master abandoned the cycle: leave quietly.
                        state_q <= ST_IDLE;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_ERR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Slave-side routing: only the frozen selection sees a strobe, and only while BUSY.
    always_comb begin
        sStbO = 4'b0000;
        if (busy) begin
            sStbO[sel_q] = wbStbI;
        end
    end

    // Master-side return path: ack and read data from the selected slave, gated to BUSY.
    always_comb begin
        wbAckO = 1'b0;
        wbDatO = '0;
        if (busy) begin
            wbAckO = sAckI[sel_q];
            wbDatO = sDatI[sel_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign wbErrO = err_q;
    assign sCycO  = busy & wbCycI;
    assign sWeO   = wbWeI;
    assign sAdrO  = wbAdrI[ADDR_WIDTH-3:0];
    assign sDatO  = wbDatI;

endmodule
